// File: rtl/baud_rate_gen_if.sv
// Baud-rate generator bundle: baud select in, oversampling/bit clocks and their rise ticks out.
interface baud_rate_gen_if;
   logic [1:0] sel_baud;
   logic       bclkx8;
   logic       bclk;
   logic       bclkx8_tick;
   logic       bclk_tick;

   modport master (
      input  sel_baud,
      output bclkx8,
      output bclk,
      output bclkx8_tick,
      output bclk_tick
   );

   modport slave (
      output sel_baud,
      input  bclkx8,
      input  bclk,
      input  bclkx8_tick,
      input  bclk_tick
   );
endinterface

// File: rtl/baud_rate_gen.sv
// UART baud-rate generator: 50%-duty bclkx8 (8x baud) and bclk (1x baud) derived from sys_clk,
// with selectable 38400/19200/9600/4800 baud and registered one-cycle rise ticks.
module baud_rate_gen #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned BASE_BAUD   = 38400
) (
   input  logic            sys_clk,
   input  logic            reset,
   baud_rate_gen_if.master bus
);

   localparam int unsigned PRESCALE = (CLK_FREQ_HZ + 8 * BASE_BAUD) / (16 * BASE_BAUD);
   localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [2:0]       div_cnt_q, div_cnt_d;
   logic [2:0]       x8_cnt_q, x8_cnt_d;
   logic             bclkx8_q, bclkx8_d;
   logic             bclk_q, bclk_d;
   logic             bclkx8_tick_q, bclkx8_tick_d;
   logic             bclk_tick_q, bclk_tick_d;

   logic             pre_tick;
   logic             x8_toggle;
   logic             bclk_toggle;
   logic [2:0]       mask;

   // Next-state: prescaler, select divider, x8 divider and tick generation
   always_comb begin
      pre_tick      = (pre_cnt_q == PRE_W'(PRESCALE - 1));
      pre_cnt_d     = pre_tick ? '0 : pre_cnt_q + PRE_W'(1);
      div_cnt_d     = pre_tick ? div_cnt_q + 3'd1 : div_cnt_q;

      // sel_baud N selects a divide-by-2^N on pre_tick, taken from the low N bits of div_cnt
      case (bus.sel_baud)
         2'b00:   mask = 3'b000;
         2'b01:   mask = 3'b001;
         2'b10:   mask = 3'b011;
         default: mask = 3'b111;
      endcase

      x8_toggle     = pre_tick && ((div_cnt_q & mask) == mask);
      bclk_toggle   = x8_toggle && (x8_cnt_q == 3'd7);

      x8_cnt_d      = x8_toggle ? x8_cnt_q + 3'd1 : x8_cnt_q;
      bclkx8_d      = x8_toggle ? ~bclkx8_q : bclkx8_q;
      bclk_d        = bclk_toggle ? ~bclk_q : bclk_q;
      bclkx8_tick_d = x8_toggle && !bclkx8_q;
      bclk_tick_d   = bclk_toggle && !bclk_q;
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         pre_cnt_q     <= '0;
         div_cnt_q     <= '0;
         x8_cnt_q      <= '0;
         bclkx8_q      <= 1'b0;
         bclk_q        <= 1'b0;
         bclkx8_tick_q <= 1'b0;
         bclk_tick_q   <= 1'b0;
      end else begin
         pre_cnt_q     <= pre_cnt_d;
         div_cnt_q     <= div_cnt_d;
         x8_cnt_q      <= x8_cnt_d;
         bclkx8_q      <= bclkx8_d;
         bclk_q        <= bclk_d;
         bclkx8_tick_q <= bclkx8_tick_d;
         bclk_tick_q   <= bclk_tick_d;
      end
   end

   assign bus.bclkx8      = bclkx8_q;
   assign bus.bclk        = bclk_q;
   assign bus.bclkx8_tick = bclkx8_tick_q;
   assign bus.bclk_tick   = bclk_tick_q;

endmodule

// File: tb/tb_baud_rate_gen.sv
// Bench for baud_rate_gen: per-select timing vectors with an expected-toggle scoreboard,
// plus hand-written mid-run reset and baud-switch sequences.
module tb_baud_rate_gen;

   typedef struct {
      logic [1:0] sel;
      int         first_x8;   // edge of first bclkx8 rise after reset release
      int         x8_per;     // bclkx8 full period
      int         b_per;      // bclk full period
      int         run;        // edges observed
   } vec_t;

   typedef struct {
      int t;
      int v;
   } evt_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   edge_n = 0;
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   bit   log_en = 1'b0;
   logic px8 = 1'b0;
   logic pb = 1'b0;

   evt_t x8_q[$];
   evt_t b_q[$];
   int   x8_log[$];
   int   b_log[$];
   vec_t vecs[4];

   baud_rate_gen_if bus ();

   baud_rate_gen dut (
      .sys_clk (clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Edge index: number of rising edges with reset low since the last reset
   always @(posedge clk) edge_n <= reset ? 0 : edge_n + 1;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s @edge %0d: got %0d expected %0d", name, edge_n, got, exp);
      end
   endtask

   // Toggle scoreboard, tick alignment and logging, sampled mid-cycle
   always @(negedge clk) begin
      evt_t e;
      if (mon_en || log_en) begin
         chk("bclkx8_tick", int'(bus.bclkx8_tick), int'(px8 == 1'b0 && bus.bclkx8 == 1'b1));
         chk("bclk_tick", int'(bus.bclk_tick), int'(pb == 1'b0 && bus.bclk == 1'b1));
      end
      if (log_en) begin
         if (bus.bclkx8 !== px8) x8_log.push_back(edge_n);
         if (bus.bclk !== pb) b_log.push_back(edge_n);
      end
      if (mon_en && bus.bclkx8 !== px8) begin
         if (x8_q.size() == 0) chk("bclkx8 unexpected toggle", edge_n, -1);
         else begin
            e = x8_q.pop_front();
            chk("bclkx8 toggle edge", edge_n, e.t);
            chk("bclkx8 level", int'(bus.bclkx8), e.v);
         end
      end
      if (mon_en && bus.bclk !== pb) begin
         if (b_q.size() == 0) chk("bclk unexpected toggle", edge_n, -1);
         else begin
            e = b_q.pop_front();
            chk("bclk toggle edge", edge_n, e.t);
            chk("bclk level", int'(bus.bclk), e.v);
         end
      end
      px8 = bus.bclkx8;
      pb  = bus.bclk;
   end

   task automatic chk_zero(input string tag);
      chk({tag, " bclkx8"}, int'(bus.bclkx8), 0);
      chk({tag, " bclk"}, int'(bus.bclk), 0);
      chk({tag, " bclkx8_tick"}, int'(bus.bclkx8_tick), 0);
      chk({tag, " bclk_tick"}, int'(bus.bclk_tick), 0);
   endtask

   task automatic do_reset(input logic [1:0] sel);
      @(negedge clk);
      reset = 1'b1;
      bus.sel_baud = sel;
      repeat (2) begin
         @(negedge clk);
         chk_zero("reset");
      end
      reset = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int run);
      int k;
      do_reset(v.sel);
      x8_q.delete();
      b_q.delete();
      k = 0;
      for (int t = v.first_x8; t <= run; t += v.x8_per / 2) begin
         x8_q.push_back('{t, (k % 2 == 0) ? 1 : 0});
         k++;
      end
      k = 0;
      for (int t = v.b_per / 2; t <= run; t += v.b_per / 2) begin
         b_q.push_back('{t, (k % 2 == 0) ? 1 : 0});
         k++;
      end
      @(posedge clk);
      mon_en = 1'b1;
      repeat (run) @(negedge clk);
      @(posedge clk);
      mon_en = 1'b0;
      chk("bclkx8 toggles missing", x8_q.size(), 0);
      chk("bclk toggles missing", b_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int prev, iv, n_steady, cnt, found;
      vecs[0] = '{2'b00, 163, 326, 2608, 6000};
      vecs[1] = '{2'b01, 326, 652, 5216, 8000};
      vecs[2] = '{2'b10, 652, 1304, 10432, 11000};
      vecs[3] = '{2'b11, 1304, 2608, 20864, 21000};
      bus.sel_baud = 2'b00;

      for (int i = 0; i < 4; i++) run_vec(vecs[i], vecs[i].run);

      // Reset while bclkx8 is high, then first-edge timing must repeat
      run_vec(vecs[0], 200);
      @(negedge clk);
      chk("pre-reset bclkx8 high", int'(bus.bclkx8), 1);
      reset = 1'b1;
      @(negedge clk);
      chk_zero("mid-run reset");
      run_vec(vecs[0], 400);

      // Switch 38400 -> 4800 mid-run
      do_reset(2'b00);
      x8_log.delete();
      b_log.delete();
      @(posedge clk);
      log_en = 1'b1;
      repeat (1000) @(negedge clk);
      bus.sel_baud = 2'b11;
      repeat (12500) @(negedge clk);
      @(posedge clk);
      log_en = 1'b0;

      prev = 0;
      n_steady = 0;
      foreach (x8_log[i]) begin
         iv = x8_log[i] - prev;
         chk("switch bclkx8 level >= 163", int'(iv >= 163), 1);
         if (prev > 1000 + 2 * 2608) begin
            chk("switch bclkx8 half-period", iv, 1304);
            n_steady++;
         end
         prev = x8_log[i];
      end
      chk("switch steady intervals seen", int'(n_steady >= 3), 1);
      chk("switch bclk toggles seen", int'(b_log.size() >= 2), 1);
      foreach (b_log[j]) begin
         found = 0;
         foreach (x8_log[i]) if (x8_log[i] == b_log[j]) found = 1;
         chk("switch bclk edge on bclkx8 edge", found, 1);
         if (j > 0) begin
            cnt = 0;
            foreach (x8_log[i]) if (x8_log[i] > b_log[j-1] && x8_log[i] <= b_log[j]) cnt++;
            chk("switch bclkx8 toggles per bclk toggle", cnt, 8);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
